// File: rtl/afe_pkg.sv
// Shared types and constants for the AFE command sequencer: command width,
// FSM state encoding, default timing values and counter-sizing helpers.
`timescale 1ns/1ps
package afe_pkg;

    localparam int unsigned AFE_CMD_W          = 20;
    localparam int unsigned DEF_GAP_CYCLES     = 4;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 64;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ROM_RD    = 3'd1,
        ST_ISSUE     = 3'd2,
        ST_WAIT_BUSY = 3'd3,
        ST_WAIT_DONE = 3'd4,
        ST_GAP       = 3'd5
    } afe_state_e;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // Bits needed to hold values 0..max_val, never less than one.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 32'd2) ? 32'd1 : $clog2(max_val + 32'd1);
    endfunction

endpackage

// File: rtl/afe_cmd_timer.sv
// Loadable down-counter shared by the inter-command gap and the transaction
// timeout; saturates at zero and reports it through zero_o.
`timescale 1ns/1ps
module afe_cmd_timer #(
    parameter int unsigned W = 8
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: load wins over decrement; hold once zero is reached.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != {W{1'b0}})) begin
            cnt_d = cnt_q - W'(1'b1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_q <= {W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == {W{1'b0}});

endmodule

// File: rtl/afe_cmd_sequencer.sv
// Drives the AFE serial command shifter: replays the init ROM on request,
// then grants single host writes, with dead time and hang detection.
`timescale 1ns/1ps
module afe_cmd_sequencer
    import afe_pkg::*;
#(
    parameter int unsigned NUM_INIT_CMDS  = 16,
    parameter int unsigned ADDR_W         = 6,
    parameter int unsigned GAP_CYCLES     = DEF_GAP_CYCLES,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 init_start_i,
    output logic [ADDR_W-1:0]    rom_addr_o,
    input  logic [AFE_CMD_W-1:0] rom_data_i,
    input  logic                 wr_req_i,
    input  logic [AFE_CMD_W-1:0] wr_data_i,
    output logic                 wr_ack_o,
    output logic                 afe_enable_o,
    output logic                 afe_start_o,
    output logic [AFE_CMD_W-1:0] afe_cmd_o,
    input  logic                 afe_done_i,
    output logic                 busy_o,
    output logic                 init_done_o,
    output logic                 timeout_err_o
);

    localparam int unsigned      TMR_W    = cnt_width(max_u(GAP_CYCLES, TIMEOUT_CYCLES));
    localparam logic [TMR_W-1:0] TO_LOAD  = TMR_W'(TIMEOUT_CYCLES - 32'd1);
    localparam logic [TMR_W-1:0] GAP_LOAD = TMR_W'(GAP_CYCLES - 32'd1);
    localparam logic [ADDR_W:0]  NUM_L    = (ADDR_W + 1)'(NUM_INIT_CMDS);
    localparam bit               NO_INIT  = (NUM_INIT_CMDS == 32'd0);

    afe_state_e           state_q;
    logic                 rd_phase_q;
    logic                 host_src_q;
    logic [ADDR_W-1:0]    index_q;
    logic [ADDR_W-1:0]    rom_addr_q;
    logic [AFE_CMD_W-1:0] afe_cmd_q;
    logic                 afe_start_q;
    logic                 afe_enable_q;
    logic                 wr_ack_q;
    logic                 busy_q;
    logic                 init_done_q;
    logic                 timeout_err_q;

    logic                 host_go;
    logic                 last_cmd;
    logic [ADDR_W-1:0]    index_nxt;
    logic                 tmr_load;
    logic                 tmr_en;
    logic [TMR_W-1:0]     tmr_val;
    logic                 tmr_zero;

    // The ack cycle is still IDLE with wr_req high; don't take the same request twice.
    assign host_go   = wr_req_i & init_done_q & ~wr_ack_q;
    assign index_nxt = index_q + ADDR_W'(1'b1);
    assign last_cmd  = (({1'b0, index_q} + (ADDR_W + 1)'(1'b1)) == NUM_L);

    // Timer control: timeout loaded on entry to ISSUE, gap loaded on entry to GAP.
    always_comb begin
        tmr_load = 1'b0;
        tmr_en   = 1'b0;
        tmr_val  = {TMR_W{1'b0}};
        case (state_q)
            ST_IDLE: begin
                if (!init_start_i && host_go) begin
                    tmr_load = 1'b1;
                    tmr_val  = TO_LOAD;
                end else begin
                    tmr_load = 1'b0;
                end
            end
            ST_ROM_RD: begin
                if (rd_phase_q) begin
                    tmr_load = 1'b1;
                    tmr_val  = TO_LOAD;
                end else begin
                    tmr_load = 1'b0;
                end
            end
            ST_ISSUE, ST_WAIT_BUSY: begin
                tmr_en = 1'b1;
            end
            ST_WAIT_DONE: begin
                if (afe_done_i) begin
                    tmr_load = 1'b1;
                    tmr_val  = GAP_LOAD;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            ST_GAP: begin
                tmr_en = 1'b1;
            end
            default: begin
                tmr_en = 1'b0;
            end
        endcase
    end

    afe_cmd_timer #(
        .W (TMR_W)
    ) u_timer (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .en_i       (tmr_en),
        .zero_o     (tmr_zero)
    );

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q       <= ST_IDLE;
            rd_phase_q    <= 1'b0;
            host_src_q    <= 1'b0;
            index_q       <= {ADDR_W{1'b0}};
            rom_addr_q    <= {ADDR_W{1'b0}};
            afe_cmd_q     <= {AFE_CMD_W{1'b0}};
            afe_start_q   <= 1'b0;
            afe_enable_q  <= 1'b0;
            wr_ack_q      <= 1'b0;
            busy_q        <= 1'b0;
            init_done_q   <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            afe_start_q <= 1'b0;
            wr_ack_q    <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (init_start_i) begin
                        timeout_err_q <= 1'b0;
                        index_q       <= {ADDR_W{1'b0}};
                        init_done_q   <= NO_INIT;
                        if (NO_INIT) begin
                            state_q <= ST_IDLE;
                        end else begin
                            rom_addr_q <= {ADDR_W{1'b0}};
                            rd_phase_q <= 1'b0;
                            host_src_q <= 1'b0;
                            busy_q     <= 1'b1;
                            state_q    <= ST_ROM_RD;
                        end
                    end else if (host_go) begin
                        afe_cmd_q    <= wr_data_i;
                        host_src_q   <= 1'b1;
                        afe_start_q  <= 1'b1;
                        afe_enable_q <= 1'b1;
                        busy_q       <= 1'b1;
                        state_q      <= ST_ISSUE;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_ROM_RD: begin
                    // Address went out on entry; the ROM word is valid one clock later.
                    if (!rd_phase_q) begin
                        rd_phase_q <= 1'b1;
                    end else begin
                        rd_phase_q   <= 1'b0;
                        afe_cmd_q    <= rom_data_i;
                        afe_start_q  <= 1'b1;
                        afe_enable_q <= 1'b1;
                        state_q      <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    state_q <= ST_WAIT_BUSY;
                end
                ST_WAIT_BUSY: begin
                    if (!afe_done_i) begin
                        state_q <= ST_WAIT_DONE;
                    end else if (tmr_zero) begin
                        timeout_err_q <= 1'b1;
                        afe_enable_q  <= 1'b0;
                        busy_q        <= 1'b0;
                        state_q       <= ST_IDLE;
                    end else begin
                        state_q <= ST_WAIT_BUSY;
                    end
                end
                ST_WAIT_DONE: begin
                    if (afe_done_i) begin
                        state_q <= ST_GAP;
                    end else if (tmr_zero) begin
                        timeout_err_q <= 1'b1;
                        afe_enable_q  <= 1'b0;
                        busy_q        <= 1'b0;
                        state_q       <= ST_IDLE;
                    end else begin
                        state_q <= ST_WAIT_DONE;
                    end
                end
                ST_GAP: begin
                    if (!tmr_zero) begin
                        state_q <= ST_GAP;
                    end else if (host_src_q) begin
                        afe_enable_q <= 1'b0;
                        wr_ack_q     <= 1'b1;
                        busy_q       <= 1'b0;
                        state_q      <= ST_IDLE;
                    end else if (last_cmd) begin
                        afe_enable_q <= 1'b0;
                        init_done_q  <= 1'b1;
                        busy_q       <= 1'b0;
                        state_q      <= ST_IDLE;
                    end else begin
                        afe_enable_q <= 1'b0;
                        index_q      <= index_nxt;
                        rom_addr_q   <= index_nxt;
                        rd_phase_q   <= 1'b0;
                        state_q      <= ST_ROM_RD;
                    end
                end
                default: begin
                    afe_enable_q <= 1'b0;
                    busy_q       <= 1'b0;
                    state_q      <= ST_IDLE;
                end
            endcase
        end
    end

    assign rom_addr_o    = rom_addr_q;
    assign wr_ack_o      = wr_ack_q;
    assign afe_enable_o  = afe_enable_q;
    assign afe_start_o   = afe_start_q;
    assign afe_cmd_o     = afe_cmd_q;
    assign busy_o        = busy_q;
    assign init_done_o   = init_done_q;
    assign timeout_err_o = timeout_err_q;

endmodule

// File: tb/tb_afe_cmd_sequencer.sv
// Directed bench for afe_cmd_sequencer with a behavioural ROM and shifter;
// a second instance covers the empty init-sequence build.
`timescale 1ns/1ps
module tb_afe_cmd_sequencer;

    localparam int GAP       = 4;
    localparam int TO        = 64;
    localparam int AW        = 6;
    localparam int SHIFT_LEN = 21;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            init_start = 1'b0;
    logic [AW-1:0]   rom_addr;
    logic [19:0]     rom_data = 20'h0;
    logic            wr_req = 1'b0;
    logic [19:0]     wr_data = 20'h0;
    logic            wr_ack, afe_enable, afe_start, busy, init_done, timeout_err;
    logic [19:0]     afe_cmd;
    logic            afe_done;
    logic            done_m;
    logic            shifter_dead = 1'b0;
    int              sh_cnt;

    logic            init_start_b = 1'b0;
    logic [AW-1:0]   rom_addr_b;
    logic [19:0]     rom_data_b = 20'h0;
    logic            wr_req_b = 1'b0;
    logic [19:0]     wr_data_b = 20'h0;
    logic            afe_done_b = 1'b1;
    logic            wr_ack_b, afe_enable_b, afe_start_b, busy_b, init_done_b, timeout_err_b;
    logic [19:0]     afe_cmd_b;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    int start_cyc[$];
    logic [19:0] start_cmd[$];
    int ack_cyc[$];
    int last_done = -1;
    int last_start = -1;
    int err_rise = -1;
    int idn_rise = -1;
    int starts_b = 0;
    logic done_prev = 1'b0, err_prev = 1'b0, idn_prev = 1'b0;

    logic [19:0] exp_rom [3] = '{20'h12345, 20'hABCDE, 20'h00001};

    afe_cmd_sequencer #(.NUM_INIT_CMDS(3), .ADDR_W(AW), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk), .reset_i(reset), .init_start_i(init_start), .rom_addr_o(rom_addr),
        .rom_data_i(rom_data), .wr_req_i(wr_req), .wr_data_i(wr_data), .wr_ack_o(wr_ack),
        .afe_enable_o(afe_enable), .afe_start_o(afe_start), .afe_cmd_o(afe_cmd),
        .afe_done_i(afe_done), .busy_o(busy), .init_done_o(init_done), .timeout_err_o(timeout_err)
    );

    afe_cmd_sequencer #(.NUM_INIT_CMDS(0), .ADDR_W(AW), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO)) dut_b (
        .clk_i(clk), .reset_i(reset), .init_start_i(init_start_b), .rom_addr_o(rom_addr_b),
        .rom_data_i(rom_data_b), .wr_req_i(wr_req_b), .wr_data_i(wr_data_b), .wr_ack_o(wr_ack_b),
        .afe_enable_o(afe_enable_b), .afe_start_o(afe_start_b), .afe_cmd_o(afe_cmd_b),
        .afe_done_i(afe_done_b), .busy_o(busy_b), .init_done_o(init_done_b), .timeout_err_o(timeout_err_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [19:0] rom_word(input logic [AW-1:0] a);
        case (a)
            6'd0:    return 20'h12345;
            6'd1:    return 20'hABCDE;
            6'd2:    return 20'h00001;
            default: return 20'hFFFFF;
        endcase
    endfunction

    // Synchronous ROM: data follows the address by one clock.
    always @(posedge clk) rom_data <= rom_word(rom_addr);

    // Shifter: done drops after start, returns after SHIFT_LEN clocks.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            sh_cnt <= 0;
            done_m <= 1'b1;
        end else if (afe_start && !shifter_dead) begin
            sh_cnt <= SHIFT_LEN;
            done_m <= 1'b0;
        end else if (sh_cnt != 0) begin
            sh_cnt <= sh_cnt - 1;
            if (sh_cnt == 1) done_m <= 1'b1;
        end
    end

    assign afe_done = shifter_dead ? 1'b1 : done_m;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Event monitor sampling on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (afe_start) begin
                if (last_done > last_start) check_eq("gap_before_start", 32'(cyc - last_done >= GAP + 1), 32'd1);
                start_cyc.push_back(cyc);
                start_cmd.push_back(afe_cmd);
                last_start = cyc;
            end
            if (afe_done && !done_prev) last_done = cyc;
            done_prev = afe_done;
            if (wr_ack) ack_cyc.push_back(cyc);
            if (timeout_err && !err_prev) err_rise = cyc;
            err_prev = timeout_err;
            if (init_done && !idn_prev) idn_rise = cyc;
            idn_prev = init_done;
            if (afe_start_b) starts_b++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_init();
        init_start = 1'b1;
        @(negedge clk);
        init_start = 1'b0;
    endtask

    task automatic wait_not_busy(input string tag, input int budget);
        int k = 0;
        while (busy && k < budget) begin
            @(negedge clk);
            k++;
        end
        check_eq(tag, 32'(busy), 32'd0);
    endtask

    task automatic wait_ack(input string tag, input int budget);
        int k = 0;
        while (!wr_ack && k < budget) begin
            @(negedge clk);
            k++;
        end
        check_eq(tag, 32'(wr_ack), 32'd1);
        check_eq({tag, "_after_gap"}, 32'(cyc - last_done), 32'(GAP + 1));
        wr_req = 1'b0;
        @(negedge clk);
        check_eq({tag, "_one_clk"}, 32'(wr_ack), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_rom_addr"}, 32'(rom_addr), 32'd0);
        check_eq({tag, "_afe_cmd"}, 32'(afe_cmd), 32'd0);
        check_eq({tag, "_ctl"}, {26'd0, wr_ack, afe_enable, afe_start, busy, init_done, timeout_err}, 32'd0);
    endtask

    task automatic check_init_words(input string tag, input int base);
        for (int i = 0; i < 3; i++) check_eq({tag, "_cmd"}, 32'(start_cmd[base + i]), 32'(exp_rom[i]));
    endtask

    initial begin
        int base;
        int k;
        tick(3);
        check_all_zero("reset");
        check_eq("reset_b_init_done", 32'(init_done_b), 32'd0);
        reset = 1'b0;
        tick(2);

        // Host write before init: must be held off.
        wr_data = 20'h5A5A5;
        wr_req  = 1'b1;
        tick(8);
        check_eq("early_wr_no_start", 32'(start_cyc.size()), 32'd0);
        check_eq("early_wr_no_ack", 32'(ack_cyc.size()), 32'd0);
        check_eq("early_wr_not_busy", 32'(busy), 32'd0);

        pulse_init();
        check_eq("init_busy", 32'(busy), 32'd1);
        wait_not_busy("init1_finish", 400);
        check_eq("init1_starts", 32'(start_cyc.size()), 32'd3);
        check_init_words("init1", 0);
        check_eq("init1_done", 32'(init_done), 32'd1);
        check_eq("init1_done_timing", 32'(idn_rise - last_done), 32'(GAP + 1));
        check_eq("init1_enable_off", 32'(afe_enable), 32'd0);

        // Held host write is served right after init.
        wait_ack("host_ack", 200);
        check_eq("host_starts", 32'(start_cyc.size()), 32'd4);
        check_eq("host_cmd", 32'(start_cmd[3]), 32'h5A5A5);
        check_eq("host_ack_count", 32'(ack_cyc.size()), 32'd1);
        tick(2);

        // init_start and wr_req together: init first, then the write.
        wr_data    = 20'h0F0F0;
        wr_req     = 1'b1;
        init_start = 1'b1;
        tick(1);
        init_start = 1'b0;
        check_eq("both_init_done_cleared", 32'(init_done), 32'd0);
        wait_ack("both_ack", 500);
        check_eq("both_starts", 32'(start_cyc.size()), 32'd8);
        check_init_words("both", 4);
        check_eq("both_host_cmd", 32'(start_cmd[7]), 32'h0F0F0);
        tick(2);

        // Dead shifter: timeout aborts the first command.
        shifter_dead = 1'b1;
        pulse_init();
        wait_not_busy("to_finish", 200);
        check_eq("to_err", 32'(timeout_err), 32'd1);
        check_eq("to_init_done", 32'(init_done), 32'd0);
        check_eq("to_enable", 32'(afe_enable), 32'd0);
        check_eq("to_starts", 32'(start_cyc.size()), 32'd9);
        check_eq("to_timing", 32'(err_rise - start_cyc[8]), 32'(TO));
        tick(3);
        check_eq("to_no_ack", 32'(ack_cyc.size()), 32'd2);
        check_eq("to_sticky", 32'(timeout_err), 32'd1);
        shifter_dead = 1'b0;
        pulse_init();
        check_eq("to_cleared", 32'(timeout_err), 32'd0);
        wait_not_busy("recover_finish", 400);
        check_eq("recover_done", 32'(init_done), 32'd1);
        check_eq("recover_starts", 32'(start_cyc.size()), 32'd12);
        check_init_words("recover", 9);
        tick(2);

        // Reset in the middle of the second init word.
        base = start_cyc.size();
        pulse_init();
        k = 0;
        while (start_cyc.size() < base + 2 && k < 300) begin
            tick(1);
            k++;
        end
        check_eq("mid_second_start", 32'(start_cyc.size()), 32'(base + 2));
        tick(5);
        check_eq("mid_rom_addr", 32'(rom_addr), 32'd1);
        check_eq("mid_busy", 32'(busy), 32'd1);
        #2 reset = 1'b1;
        #1 check_all_zero("async_reset");
        tick(3);
        reset = 1'b0;
        tick(1);
        base = start_cyc.size();
        pulse_init();
        check_eq("restart_rom_addr", 32'(rom_addr), 32'd0);
        wait_not_busy("restart_finish", 400);
        check_eq("restart_starts", 32'(start_cyc.size()), 32'(base + 3));
        check_init_words("restart", base);
        check_eq("restart_done", 32'(init_done), 32'd1);

        // Empty init sequence build.
        init_start_b = 1'b1;
        tick(1);
        init_start_b = 1'b0;
        check_eq("zero_init_done", 32'(init_done_b), 32'd1);
        check_eq("zero_busy", 32'(busy_b), 32'd0);
        tick(3);
        check_eq("zero_no_start", 32'(starts_b), 32'd0);
        check_eq("zero_init_done_held", 32'(init_done_b), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #400000;
        n_checks++;
        n_errors++;
        $display("FAIL watchdog: got no completion, expected completion within 400000 ns");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/afe_cmd_sequencer.md
Name: afe_cmd_sequencer

Overview:
Controller that drives the AFE 20-bit serial command shifter.
- On request, it walks an external init-command ROM and issues each word as one serial transaction.
- After init completes, it grants single runtime writes from a host port.
- It owns the shifter's enable/start/data inputs, watches its done flag, enforces inter-command dead time and flags hung transactions.

Parameters:
NUM_INIT_CMDS, 16, number of ROM words issued per init sequence (0 allowed)
ADDR_W, 6, ROM address width; must satisfy 2^ADDR_W >= NUM_INIT_CMDS
GAP_CYCLES, 4, idle clocks between the shifter's done and the next start (>=1)
TIMEOUT_CYCLES, 64, max clocks from start to done before abort (>=24)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
init_start  in  1  one-cycle pulse; begins init sequence
rom_addr  out  ADDR_W  init ROM address, registered
rom_data  in  20  ROM word, valid exactly 1 clk after rom_addr changes
wr_req  in  1  host write request, level, held until wr_ack
wr_data  in  20  host command word, stable while wr_req=1
wr_ack  out  1  one-cycle pulse when host write transaction completes
afe_enable  out  1  shifter enable
afe_start  out  1  shifter start_transaction, one-cycle pulse
afe_cmd  out  20  shifter parallel_input, registered
afe_done  in  1  shifter transaction_done
busy  out  1  high in any state other than IDLE
init_done  out  1  high after a full init sequence, until next init_start or reset
timeout_err  out  1  sticky; cleared only by init_start or reset

Behaviour:
- Reset (async, any state): state=IDLE; all outputs 0; index and counters 0.
- States: IDLE, ROM_RD, ISSUE, WAIT_BUSY, WAIT_DONE, GAP.
- IDLE, priority order:
  - init_start: clear init_done and timeout_err, index=0. Go ROM_RD, or if NUM_INIT_CMDS=0 set init_done and stay.
  - else wr_req && init_done: latch wr_data into afe_cmd, mark host source, go ISSUE.
  - wr_req while init_done=0: held, not acked.
- ROM_RD: rom_addr=index for 1 clk. Next clk: latch rom_data into afe_cmd, go ISSUE.
- ISSUE: afe_start=1 for exactly this cycle; afe_enable=1 from ISSUE through GAP; afe_cmd held stable until GAP exits; go WAIT_BUSY.
- WAIT_BUSY: wait for afe_done=0, confirming the shifter left idle; then go WAIT_DONE.
- WAIT_DONE: wait for afe_done=1.
  - Then GAP_CYCLES of GAP, with afe_start=0.
  - Timeout counter runs from ISSUE through WAIT_DONE.
  - On reaching TIMEOUT_CYCLES in WAIT_BUSY or WAIT_DONE: set timeout_err, deassert afe_enable, abort to IDLE; init_done stays 0; no wr_ack.
- GAP exit:
  - Host source: wr_ack=1 for one clk, go IDLE.
  - Init source: index+1. If index+1 == NUM_INIT_CMDS, set init_done and go IDLE; else go ROM_RD.
- init_start while busy: ignored. wr_req during init: held, served after init_done.
- Index counter is ADDR_W bits and never wraps, since the terminal compare precedes the increment.
- Typical per-command latency with the 20-bit shifter: ROM_RD 2 + ISSUE 1 + ~23 shift/done + GAP_CYCLES.

Decomposition:
- Shared package afe_pkg: AFE_CMD_W=20, state encoding constants, default GAP/TIMEOUT values.
- One natural sub-module, afe_cmd_timer: a loadable down-counter serving both the gap and timeout counts, with load value, enable and zero flag.
- Top instantiates afe_cmd_timer plus the existing serial shifter in the integration level, not inside this block.

Test Plan:
- NUM_INIT_CMDS=3; ROM = 0x12345, 0xABCDE, 0x00001; pulse init_start -> three afe_start pulses with afe_cmd equal to those words in order; each start is >= GAP_CYCLES+1 clks after the prior afe_done rise; init_done=1 after the third GAP.
- After init, wr_req with wr_data=0x5A5A5 -> one afe_start with afe_cmd=0x5A5A5, wr_ack pulse 1 clk after GAP; wr_req before init_done -> no start, no ack until init completes.
- afe_done tied 1 (shifter dead) -> after TIMEOUT_CYCLES, timeout_err=1, busy=0, init_done=0; next init_start clears timeout_err.
- init_start and wr_req in the same IDLE cycle with init_done=1 -> init sequence runs first; host write is issued after init completes.
- Assert reset mid-shift of the 2nd init word -> all outputs 0 asynchronously; after release, init_start restarts from rom_addr=0.
- NUM_INIT_CMDS=0 build: init_start -> init_done=1 next clk, no afe_start.
